// File: rtl/uart_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_hex_tx
//  Purpose  : Formats a 32-bit value as ASCII hexadecimal text and streams it
//             byte by byte into a uart_tx style valid/ready handshake. The
//             frame is an optional leading '-', DIGITS uppercase hex chars
//             (MS nibble first, leading zeros kept), then an optional CR LF.
//  Ports    : clk       - system clock
//             rstn      - asynchronous active-low reset
//             send      - frame request, sampled only while idle
//             data[31:0]- value to format, latched on an accepted send
//             sign      - prefix frame with '-', latched with data
//             busy      - frame in progress
//             done      - one-cycle pulse after the final byte is accepted
//             tx_start  - byte valid toward uart_tx (equals busy)
//             tx_data   - byte presented toward uart_tx
//             tx_avai   - uart_tx ready; transfer on tx_start & tx_avai
//  Revision : 1.0 - initial release
// ============================================================================
module uart_hex_tx #(
   parameter int DIGITS  = 8,     // 1..8 hex characters per frame
   parameter bit NEWLINE = 1'b1   // append CR LF after the digits
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        send,
   input  logic [31:0] data,
   input  logic        sign,
   output logic        busy,
   output logic        done,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_avai
);

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_SIGN = 3'd1;
   localparam logic [2:0] c_ST_HEX  = 3'd2;
   localparam logic [2:0] c_ST_CR   = 3'd3;
   localparam logic [2:0] c_ST_LF   = 3'd4;

   localparam logic [2:0] c_IDX_INIT = 3'(DIGITS - 1);

   logic [2:0]  state_q, state_d;
   logic [2:0]  idx_q,   idx_d;
   logic [31:0] data_q,  data_d;
   logic        sign_q,  sign_d;
   logic        done_q,  done_d;

   logic [2:0]  w_hex_exit;
   logic [3:0]  w_nibble;
   logic [7:0]  w_ascii;

   // Where the last digit goes: the terminator, or straight back to idle.
   generate
      if (NEWLINE) begin : g_newline
         assign w_hex_exit = c_ST_CR;
      end else begin : g_no_newline
         assign w_hex_exit = c_ST_IDLE;
      end
   endgenerate

   // Selected nibble and its uppercase ASCII code ('0'-'9', 'A'-'F').
   assign w_nibble = 4'(data_q >> {idx_q, 2'b00});
   assign w_ascii  = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                        : (8'h37 + {4'h0, w_nibble});

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= c_ST_IDLE;
         idx_q   <= c_IDX_INIT;
         data_q  <= 32'h0;
         sign_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         sign_q  <= sign_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. In every non-idle state tx_start is high, so a
   // handshake is simply tx_avai.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      sign_d  = sign_q;
      case (state_q)
         c_ST_IDLE: begin
            if (send) begin
               data_d  = data;
               sign_d  = sign;
               idx_d   = c_IDX_INIT;
               state_d = sign ? c_ST_SIGN : c_ST_HEX;
            end
         end
         c_ST_SIGN: begin
            if (tx_avai) state_d = c_ST_HEX;
         end
         c_ST_HEX: begin
            if (tx_avai) begin
               if (idx_q != 3'd0) idx_d   = idx_q - 3'd1;
               else               state_d = w_hex_exit;
            end
         end
         c_ST_CR: begin
            if (tx_avai) state_d = c_ST_LF;
         end
         c_ST_LF: begin
            if (tx_avai) state_d = c_ST_IDLE;
         end
         default: state_d = c_ST_IDLE;
      endcase
      // Completion is any return to idle from a sending state; reset is the
      // only other way back and it clears done_q instead.
      done_d = (state_q != c_ST_IDLE) && (state_d == c_ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registered state only, never from tx_avai.
   // ------------------------------------------------------------------------
   always_comb begin
      busy     = (state_q != c_ST_IDLE);
      tx_start = busy;
      done     = done_q;
      case (state_q)
         // SIGN is only entered with sign_q set; the gate keeps a corrupted
         // state from ever emitting a spurious '-'.
         c_ST_SIGN: tx_data = sign_q ? 8'h2D : 8'h00;
         c_ST_HEX:  tx_data = w_ascii;
         c_ST_CR:   tx_data = 8'h0D;
         c_ST_LF:   tx_data = 8'h0A;
         default:   tx_data = 8'h00;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_hex_tx
//  Purpose  : Self-checking bench for uart_hex_tx. Instance A uses the
//             default build (8 digits, CR LF); instance B is built with
//             4 digits and no terminator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_tx;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A signals
   logic        a_rstn, a_send, a_sign, a_avai;
   logic [31:0] a_data;
   logic        a_busy, a_done, a_tx_start;
   logic [7:0]  a_tx_data;

   // Instance B signals
   logic        b_rstn, b_send, b_sign, b_avai;
   logic [31:0] b_data;
   logic        b_busy, b_done, b_tx_start;
   logic [7:0]  b_tx_data;

   uart_hex_tx u_dut_a (
      .clk(clk), .rstn(a_rstn), .send(a_send), .data(a_data), .sign(a_sign),
      .busy(a_busy), .done(a_done), .tx_start(a_tx_start),
      .tx_data(a_tx_data), .tx_avai(a_avai)
   );

   uart_hex_tx #(.DIGITS(4), .NEWLINE(1'b0)) u_dut_b (
      .clk(clk), .rstn(b_rstn), .send(b_send), .data(b_data), .sign(b_sign),
      .busy(b_busy), .done(b_done), .tx_start(b_tx_start),
      .tx_data(b_tx_data), .tx_avai(b_avai)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int  done_cnt, done_idx, stable_err, both_err;
   bit  timed_out, first_busy;

   // Reference model: the text a frame should contain.
   task automatic build_exp(input logic [31:0] d, input bit s, input int digits, input bit nl);
      exp_q.delete();
      if (s) exp_q.push_back(8'h2D);
      for (int i = digits - 1; i >= 0; i--) begin
         int n;
         n = int'((d >> (4 * i)) & 32'hF);
         if (n < 10) exp_q.push_back(8'(48 + n));
         else        exp_q.push_back(8'(65 + n - 10));
      end
      if (nl) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   // Requests a frame on A; returns at the slot of cycle N+1.
   task automatic start_a(input logic [31:0] d, input bit s);
      a_data = d; a_sign = s; a_send = 1'b1;
      @(posedge clk); #1;
      a_send = 1'b0;
   endtask

   // Drives tx_avai on A and records transferred bytes until done (plus a
   // few idle cycles). mode 0: ready always; 1: random; 2: random with a
   // 50-cycle stall mid-digits. disturb: pulse send / change data while busy.
   task automatic collect_a(input int mode, input bit disturb, input int max_cyc);
      int hold; bit held; bit prev_stall; logic [7:0] prev_data;
      got_q.delete();
      done_cnt = 0; done_idx = -1; stable_err = 0; both_err = 0; timed_out = 0;
      first_busy = a_busy;
      hold = 0; held = 0; prev_stall = 0; prev_data = 8'h00;
      for (int k = 0; k < max_cyc; k++) begin
         if (a_done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = k;
         end
         if (a_done && a_busy) both_err++;
         if (prev_stall && (!a_tx_start || a_tx_data !== prev_data)) stable_err++;
         if (done_idx >= 0 && k >= done_idx + 3) break;
         if (mode == 0) a_avai = 1'b1;
         else begin
            if (mode == 2 && !held && got_q.size() == 4) begin held = 1; hold = 50; end
            if (hold > 0) begin a_avai = 1'b0; hold--; end
            else a_avai = 1'($urandom_range(0, 1));
         end
         if (disturb && a_busy) begin
            a_send = 1'($urandom_range(0, 1));
            a_data = $urandom;
            a_sign = 1'($urandom_range(0, 1));
         end else a_send = 1'b0;
         if (a_tx_start && a_avai) got_q.push_back(a_tx_data);
         prev_stall = a_tx_start && !a_avai;
         prev_data  = a_tx_data;
         @(posedge clk); #1;
      end
      if (done_idx < 0) timed_out = 1;
      a_avai = 1'b1; a_send = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset;
      a_rstn = 1'b0; b_rstn = 1'b0;
      #3;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
      checks++; if (a_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", a_tx_start); end
      checks++; if (a_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", a_tx_data); end
      checks++; if (b_busy !== 1'b0 || b_tx_start !== 1'b0) begin errors++; $display("FAIL reset_b got=%b%b exp=00", b_busy, b_tx_start); end
      repeat (2) @(posedge clk);
      #1;
      a_rstn = 1'b1; b_rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_frame;
      build_exp(32'h1234ABCD, 1'b0, 8, 1'b1);
      start_a(32'h1234ABCD, 1'b0);
      collect_a(0, 1'b0, 40);
      checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL basic_first_busy got=%b exp=1", first_busy); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_idx, exp_q.size()); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
      checks++; if (both_err != 0) begin errors++; $display("FAIL basic_done_busy_overlap got=%0d exp=0", both_err); end
   endtask

   task automatic test_sign_frame;
      build_exp(32'h0000000F, 1'b1, 8, 1'b1);
      start_a(32'h0000000F, 1'b1);
      checks++; if (a_tx_data !== 8'h2D) begin errors++; $display("FAIL sign_first_byte got=%h exp=2d", a_tx_data); end
      collect_a(0, 1'b0, 40);
      checks++; if (got_q.size() != 11) begin errors++; $display("FAIL sign_len got=%0d exp=11", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sign_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_idx != 11 || done_cnt != 1) begin errors++; $display("FAIL sign_done got=%0d/%0d exp=11/1", done_idx, done_cnt); end
   endtask

   task automatic test_stall;
      for (int f = 0; f < 6; f++) begin
         logic [31:0] d; bit s;
         d = $urandom; s = 1'($urandom_range(0, 1));
         build_exp(d, s, 8, 1'b1);
         start_a(d, s);
         collect_a((f == 0) ? 2 : 1, 1'b0, 400);
         checks++; if (timed_out) begin errors++; $display("FAIL stall%0d_timeout got=no_done exp=done", f); end
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall%0d_len got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall%0d_byte%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
         end
         checks++; if (stable_err != 0) begin errors++; $display("FAIL stall%0d_hold got=%0d exp=0", f, stable_err); end
         checks++; if (done_cnt != 1 || both_err != 0) begin errors++; $display("FAIL stall%0d_done got=%0d/%0d exp=1/0", f, done_cnt, both_err); end
      end
   endtask

   task automatic test_ignore_while_busy;
      for (int f = 0; f < 3; f++) begin
         logic [31:0] d; bit s;
         d = $urandom; s = 1'(f & 1);
         build_exp(d, s, 8, 1'b1);
         start_a(d, s);
         collect_a(1, 1'b1, 400);
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL busy%0d_len got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy%0d_byte%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
         end
         checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy%0d_done_count got=%0d exp=1", f, done_cnt); end
         checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy%0d_idle_after got=%b exp=0", f, a_busy); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d2; bit s2; int idx;
      b_avai = 1'b1;
      build_exp(32'hFFFF1234, 1'b0, 4, 1'b0);
      b_data = 32'hFFFF1234; b_sign = 1'b0; b_send = 1'b1;
      @(posedge clk); #1;
      b_send = 1'b0;
      got_q.delete(); idx = -1;
      for (int k = 0; k < 20; k++) begin
         if (b_done) begin idx = k; break; end
         if (b_tx_start && b_avai) got_q.push_back(b_tx_data);
         @(posedge clk); #1;
      end
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL b2b_len got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (idx != 4) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=4", idx); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got=%b exp=0", b_busy); end
      // Request the next frame in the done cycle.
      d2 = $urandom; s2 = 1'b1;
      build_exp(d2, s2, 4, 1'b0);
      b_data = d2; b_sign = s2; b_send = 1'b1;
      @(posedge clk); #1;
      b_send = 1'b0; b_data = 32'h0;
      checks++; if (b_busy !== 1'b1 || b_tx_start !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b%b exp=11", b_busy, b_tx_start); end
      got_q.delete(); idx = -1;
      for (int k = 0; k < 20; k++) begin
         if (b_done) begin idx = k; break; end
         if (b_tx_start && b_avai) got_q.push_back(b_tx_data);
         @(posedge clk); #1;
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b2_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b2_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (idx != 5) begin errors++; $display("FAIL b2b2_done_cycle got=%0d exp=5", idx); end
   endtask

   task automatic test_async_abort;
      bit saw_done;
      build_exp(32'hCAFE0123, 1'b1, 8, 1'b1);
      a_avai = 1'b1;
      start_a(32'hCAFE0123, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_busy !== 1'b1 || a_tx_data !== exp_q[3]) begin errors++; $display("FAIL abort_pre got=%b/%h exp=1/%h", a_busy, a_tx_data, exp_q[3]); end
      a_rstn = 1'b0;
      #2;  // still before the next clock edge
      checks++; if (a_tx_start !== 1'b0) begin errors++; $display("FAIL abort_tx_start got=%b exp=0", a_tx_start); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", a_busy); end
      saw_done = a_done;
      repeat (2) begin
         @(posedge clk); #1;
         saw_done |= a_done;
      end
      a_rstn = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         saw_done |= a_done;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
      build_exp(32'h89ABCDEF, 1'b0, 8, 1'b1);
      start_a(32'h89ABCDEF, 1'b0);
      collect_a(0, 1'b0, 40);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_restart_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_restart_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_restart_done got=%0d exp=1", done_cnt); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_rstn = 1'b0; a_send = 1'b0; a_sign = 1'b0; a_avai = 1'b1; a_data = 32'h0;
      b_rstn = 1'b0; b_send = 1'b0; b_sign = 1'b0; b_avai = 1'b1; b_data = 32'h0;
      @(posedge clk); #1;
      test_reset();
      test_basic_frame();
      test_sign_frame();
      test_stall();
      test_ignore_while_busy();
      test_back_to_back();
      test_async_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_hex_tx.md
# uart_hex_tx

Formats a 32-bit value as ASCII hexadecimal text and streams it byte by byte into the UART transmitter's `tx_start`/`tx_data`/`tx_avai` handshake. The output can carry an optional leading '-' and a trailing CR LF. The block sits between the board calculator or result logic and `uart_tx`, so a result shown on the digital tubes can also be sent to the host. It is the sending counterpart to the byte-echo path, which only consumes received bytes.

## Interface
Parameters:
- `DIGITS`, default 8: hex characters per frame, legal range 1..8; the least-significant `DIGITS` nibbles are sent.
- `NEWLINE`, default 1: when 1, append 0x0D then 0x0A after the digits; when 0, send no terminator.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rstn`  in  1: reset, asynchronous, active-low.
- `send`  in  1: request a frame; sampled only when idle.
- `data`  in  32: value to format; latched on an accepted `send`.
- `sign`  in  1: when 1, prefix the frame with '-' (0x2D); latched with `data`.
- `busy`  out  1: high while a frame is in progress.
- `done`  out  1: one-cycle pulse after the final byte of a frame is accepted.
- `tx_start`  out  1: byte valid toward `uart_tx`.
- `tx_data`  out  8: byte presented toward `uart_tx`.
- `tx_avai`  in  1: `uart_tx` ready; a byte transfers in any cycle with `tx_start & tx_avai`.

## Operation
- States: IDLE, SIGN, HEX, CR, LF.
- `busy` = (state != IDLE). `tx_start` = busy.
- IDLE:
  - On `send` high, register `data` and `sign`.
  - Load the nibble index to `DIGITS-1`.
  - Go to SIGN if `sign`, otherwise go to HEX.
- SIGN: `tx_data`=0x2D; on handshake go to HEX.
- HEX:
  - `tx_data` is the ASCII encoding of nibble[idx] of the latched data, most-significant selected nibble first.
  - Values 0..9 map to 0x30..0x39; values A..F map to 0x41..0x46, uppercase only.
  - On handshake with idx>0, decrement idx.
  - On handshake with idx==0, go to CR if `NEWLINE`, otherwise go to IDLE.
- CR: `tx_data`=0x0D; on handshake go to LF.
- LF: `tx_data`=0x0A; on handshake go to IDLE.
- Every transition into IDLE from a sending state registers `done`=1 for exactly one cycle.
- Leading zeros are always sent; there is no zero suppression.
- Frame length in bytes = `sign` + `DIGITS` + 2·`NEWLINE`.
- `send` while busy is ignored, with no queuing. `data` and `sign` changes while busy have no effect.
- `tx_data` depends only on registered state; it never combinationally depends on `tx_avai`.
- Reset values (async, `rstn`=0): state IDLE, `busy`=0, `done`=0, `tx_start`=0, `tx_data`=0x00, idx=`DIGITS-1`, latched data and sign cleared.
- Reset asserted mid-frame aborts immediately: `tx_start` drops without waiting for the clock and no `done` pulse is produced.

## Timing
- `send` sampled high in cycle N (while idle) gives `busy`=1, `tx_start`=1 and the first byte on `tx_data` in cycle N+1.
- With `tx_avai` held high, one byte transfers per cycle. The next byte appears in the cycle after each handshake.
- With `tx_avai` low, `tx_start` stays high and `tx_data` holds stable indefinitely.
- After the final handshake in cycle M, cycle M+1 has `busy`=0 and `done`=1. A `send` in cycle M+1 is accepted, so frames can run back to back with the first byte in M+2.
- `done` and `busy` are never high together.

## Test plan
- `DIGITS`=8, `NEWLINE`=1, `tx_avai`=1, `send` with data 0x1234ABCD and `sign`=0 -> bytes 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles, then a single `done` pulse.
- `sign`=1, data 0x0000000F -> bytes 2D 30 30 30 30 30 30 30 46 0D 0A (11 bytes).
- `tx_avai` toggled randomly, including held low for 50 cycles mid-digit -> same byte sequence, `tx_data` stable throughout stalls, and no byte skipped or duplicated.
- `send` pulsed during a frame, and `data` changed mid-frame -> no effect; the frame completes with the original value and exactly one `done`.
- Build with `DIGITS`=4, `NEWLINE`=0, data 0xFFFF1234 -> bytes 31 32 33 34 only. `done` is high in the cycle after the 4th handshake, and a `send` in that cycle starts the next frame one cycle later.
- `rstn` pulsed low after 3 bytes of a frame -> `tx_start`=0 and `busy`=0 asynchronously, with no `done` pulse. A fresh `send` afterward restarts from the first byte.
